// File: rtl/m_mem_access_ctrl.sv
// Memory-stage load/store unit: alignment/map checks, req/ack bus master, load extension.
// Optional MEM_TIMEOUT_EN aborts a bus access after TIMEOUT_CYCLES cycles without bus_ack.
module m_mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_addr_ovf,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exc_adel,
    output logic        exc_ades
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  op_q, op_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        exc_adel_q, exc_adel_d;
    logic        exc_ades_q, exc_ades_d;

    logic        is_store, is_word, is_half;
    logic        in_dm, in_tc, in_ig, misaligned, fault;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, load_ext;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;

    assign is_store = req_op[2] & (req_op[1] | req_op[0]);
    assign is_word  = (req_op == 3'b000) || (req_op == 3'b101);
    assign is_half  = (req_op == 3'b001) || (req_op == 3'b010) || (req_op == 3'b110);

    assign in_dm = (req_addr <= 32'h0000_2FFF);
    assign in_tc = ((req_addr >= 32'h0000_7F00) && (req_addr <= 32'h0000_7F0B)) ||
                   ((req_addr >= 32'h0000_7F10) && (req_addr <= 32'h0000_7F1B));
    assign in_ig = (req_addr >= 32'h0000_7F20) && (req_addr <= 32'h0000_7F23);

    assign misaligned = (is_word && (req_addr[1:0] != 2'b00)) || (is_half && req_addr[0]);

    // Timer/counter registers only accept full-word accesses, and the count registers are read-only.
    assign fault = req_addr_ovf || misaligned || !(in_dm || in_tc || in_ig) ||
                   (in_tc && !is_word) ||
                   (is_store && ((req_addr == 32'h0000_7F08) || (req_addr == 32'h0000_7F18)));

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
        if (is_half) begin
            be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{req_wdata[15:0]}};
        end else if (!is_word) begin
            be_calc    = 4'b0001 << req_addr[1:0];
            wdata_calc = {4{req_wdata[7:0]}};
        end
    end

    always_comb begin
        rd_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (addr_q[1:0])
            2'b00:   rd_byte = bus_rdata[7:0];
            2'b01:   rd_byte = bus_rdata[15:8];
            2'b10:   rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        case (op_q)
            3'b000:  load_ext = bus_rdata;
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_ext = {16'h0000, rd_half};
            3'b011:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'h00_0000, rd_byte};
            default: load_ext = 32'h0;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired;
    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        addr_d       = addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        op_d         = op_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        exc_adel_d   = 1'b0;
        exc_ades_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = '0;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                op_d   = req_op;
                addr_d = req_addr;
                if (fault) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    exc_adel_d   = !is_store;
                    exc_ades_d   = is_store;
                end else begin
                    state_d     = BUS;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_be_d    = be_calc;
                    bus_wdata_d = wdata_calc;
                end
            end
            BUS: begin
                if (bus_ack) begin
                    state_d      = RESP;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = bus_we_q ? 32'h0 : load_ext;
                end
`ifdef MEM_TIMEOUT_EN
                else if (expired) begin
                    state_d      = RESP;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    exc_adel_d   = !bus_we_q;
                    exc_ades_d   = bus_we_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            addr_q       <= 32'h0;
            bus_be_q     <= 4'h0;
            bus_wdata_q  <= 32'h0;
            op_q         <= 3'b000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            exc_adel_q   <= 1'b0;
            exc_ades_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            addr_q       <= addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            op_q         <= op_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            exc_adel_q   <= exc_adel_d;
            exc_ades_q   <= exc_ades_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = {addr_q[31:2], 2'b00};
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign busy       = ((state_q == IDLE) && req_valid) || (state_q == BUS);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign exc_adel   = exc_adel_q;
    assign exc_ades   = exc_ades_q;
endmodule

// File: tb/tb_m_mem_access_ctrl.sv
// Directed bench for m_mem_access_ctrl: loads, stores, wait states, faults, reset mid-access.
module tb_m_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        req_addr_ovf;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        busy, resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_adel, exc_ades;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] LW = 3'b000, LB = 3'b011, LBU = 3'b100, LHU = 3'b010;
    localparam logic [2:0] SW = 3'b101, SH = 3'b110, SB = 3'b111;

    m_mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_addr_ovf(req_addr_ovf),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    always #5 clk = ~clk;

    // Observations of one access, all sampled on the falling edge.
    int          o_lat, o_reqc;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic        o_we, o_adel, o_ades, o_bad;

    task automatic do_access(input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic ovf,
                             input int wait_n, input logic [31:0] rdata);
        int waited = 0;
        o_lat = -1; o_reqc = 0; o_bad = 1'b0;
        o_be = 'x; o_addr = 'x; o_wdata = 'x; o_we = 1'bx;
        o_rdata = 'x; o_adel = 1'bx; o_ades = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_wdata = wdata; req_addr_ovf = ovf;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            #1;
            if (resp_valid) begin
                o_lat = cyc; o_rdata = resp_rdata; o_adel = exc_adel; o_ades = exc_ades;
                if (busy || bus_req) o_bad = 1'b1;
                break;
            end
            if (!busy) o_bad = 1'b1;
            if (bus_req) begin
                if (o_reqc == 0) begin
                    o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
                end else if (o_be !== bus_be || o_addr !== bus_addr ||
                             o_wdata !== bus_wdata || o_we !== bus_we) begin
                    o_bad = 1'b1;
                end
                o_reqc++;
                if (waited == wait_n) begin
                    bus_ack = 1'b1; bus_rdata = rdata;
                end else begin
                    bus_ack = 1'b0; waited++;
                end
            end else begin
                bus_ack = 1'b0;
            end
            @(negedge clk);
            bus_ack = 1'b0;
        end
        req_valid = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = LW; req_addr = 0; req_wdata = 0;
        req_addr_ovf = 1'b0; bus_ack = 1'b0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, busy, resp_valid, resp_rdata,
             exc_adel, exc_ades} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero, bus_req=%b busy=%b resp_valid=%b",
                               bus_req, busy, resp_valid);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        do_access(LW, 32'h0000_1004, 32'h0, 1'b0, 0, 32'h1234_5678);
        checks++;
        if (o_lat !== 3 || o_reqc !== 1 || o_bad) begin
            errors++; $display("FAIL lw_timing: lat=%0d reqc=%0d bad=%b want 3 1 0", o_lat, o_reqc, o_bad);
        end
        checks++;
        if (o_be !== 4'b1111 || o_addr !== 32'h1004 || o_we !== 1'b0) begin
            errors++; $display("FAIL lw_bus: be=%b addr=%h we=%b want 1111 00001004 0", o_be, o_addr, o_we);
        end
        checks++;
        if (o_rdata !== 32'h1234_5678 || o_adel !== 1'b0 || o_ades !== 1'b0) begin
            errors++; $display("FAIL lw_resp: rdata=%h adel=%b ades=%b want 12345678 0 0", o_rdata, o_adel, o_ades);
        end
    endtask

    task automatic test_byte_loads();
        do_access(LB, 32'h0000_0003, 32'h0, 1'b0, 0, 32'h80FF_0000);
        checks++;
        if (o_be !== 4'b1000 || o_rdata !== 32'hFFFF_FF80 || o_addr !== 32'h0) begin
            errors++; $display("FAIL lb: be=%b rdata=%h addr=%h want 1000 ffffff80 0", o_be, o_rdata, o_addr);
        end
        do_access(LBU, 32'h0000_0003, 32'h0, 1'b0, 0, 32'h80FF_0000);
        checks++;
        if (o_be !== 4'b1000 || o_rdata !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu: be=%b rdata=%h want 1000 00000080", o_be, o_rdata);
        end
        do_access(LHU, 32'h0000_0102, 32'h0, 1'b0, 1, 32'h8001_7FFF);
        checks++;
        if (o_be !== 4'b1100 || o_rdata !== 32'h0000_8001 || o_lat !== 4) begin
            errors++; $display("FAIL lhu: be=%b rdata=%h lat=%0d want 1100 00008001 4", o_be, o_rdata, o_lat);
        end
    endtask

    task automatic test_store_wait();
        do_access(SH, 32'h0000_0102, 32'hAAAA_BEEF, 1'b0, 4, 32'hDEAD_DEAD);
        checks++;
        if (o_wdata !== 32'hBEEF_BEEF || o_be !== 4'b1100 || o_we !== 1'b1 || o_addr !== 32'h100) begin
            errors++; $display("FAIL sh_bus: wdata=%h be=%b we=%b addr=%h want beefbeef 1100 1 100",
                               o_wdata, o_be, o_we, o_addr);
        end
        checks++;
        if (o_reqc !== 5 || o_lat !== 7 || o_bad) begin
            errors++; $display("FAIL sh_timing: reqc=%0d lat=%0d bad=%b want 5 7 0", o_reqc, o_lat, o_bad);
        end
        checks++;
        if (o_rdata !== 32'h0 || o_ades !== 1'b0) begin
            errors++; $display("FAIL sh_resp: rdata=%h ades=%b want 0 0", o_rdata, o_ades);
        end
        do_access(SB, 32'h0000_0011, 32'h0000_00A5, 1'b0, 0, 32'h0);
        checks++;
        if (o_wdata !== 32'hA5A5_A5A5 || o_be !== 4'b0010 || o_lat !== 3) begin
            errors++; $display("FAIL sb_bus: wdata=%h be=%b lat=%0d want a5a5a5a5 0010 3", o_wdata, o_be, o_lat);
        end
    endtask

    task automatic test_faults();
        logic [2:0]  ops[6]   = '{LW, SW, SB, LW, LW, SW};
        logic [31:0] addrs[6] = '{32'h2, 32'h7F08, 32'h7F00, 32'h100, 32'h3000, 32'h1001};
        logic        ovfs[6]  = '{0, 0, 0, 1, 0, 0};
        logic        ades[6]  = '{0, 1, 1, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            do_access(ops[i], addrs[i], 32'h1111_1111, ovfs[i], 0, 32'hFFFF_FFFF);
            checks++;
            if (o_lat !== 2 || o_reqc !== 0 || o_adel !== !ades[i] || o_ades !== ades[i] ||
                o_rdata !== 32'h0) begin
                errors++; $display("FAIL fault_%0d: lat=%0d reqc=%0d adel=%b ades=%b rdata=%h want 2 0 %b %b 0",
                                   i, o_lat, o_reqc, o_adel, o_ades, o_rdata, !ades[i], ades[i]);
            end
        end
        // Legal edges of the map still reach the bus.
        do_access(LW, 32'h0000_7F08, 32'h0, 1'b0, 0, 32'h0000_0042);
        checks++;
        if (o_lat !== 3 || o_adel !== 1'b0 || o_rdata !== 32'h42) begin
            errors++; $display("FAIL lw_tc_count: lat=%0d adel=%b rdata=%h want 3 0 42", o_lat, o_adel, o_rdata);
        end
        do_access(SB, 32'h0000_7F23, 32'h77, 1'b0, 0, 32'h0);
        checks++;
        if (o_lat !== 3 || o_ades !== 1'b0 || o_be !== 4'b1000) begin
            errors++; $display("FAIL sb_ig_edge: lat=%0d ades=%b be=%b want 3 0 1000", o_lat, o_ades, o_be);
        end
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_ack: resp_valid=%b bus_req=%b busy=%b want 0 0 0",
                               resp_valid, bus_req, busy);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        do_access(SW, 32'h0000_0010, 32'h5, 1'b0, 1000, 32'h0);
        checks++;
        if (o_reqc !== 8 || o_lat !== 10 || o_ades !== 1'b1 || o_adel !== 1'b0 || o_rdata !== 32'h0) begin
            errors++; $display("FAIL timeout: reqc=%0d lat=%0d ades=%b adel=%b rdata=%h want 8 10 1 0 0",
                               o_reqc, o_lat, o_ades, o_adel, o_rdata);
        end
        do_access(LW, 32'h0000_0010, 32'h0, 1'b0, 7, 32'h0000_ABCD);
        checks++;
        if (o_reqc !== 8 || o_adel !== 1'b0 || o_rdata !== 32'h0000_ABCD) begin
            errors++; $display("FAIL ack_at_expiry: reqc=%0d adel=%b rdata=%h want 8 0 0000abcd",
                               o_reqc, o_adel, o_rdata);
        end
    endtask
`else
    task automatic test_long_wait();
        do_access(SW, 32'h0000_0010, 32'h5, 1'b0, 20, 32'h0);
        checks++;
        if (o_reqc !== 21 || o_lat !== 23 || o_ades !== 1'b0 || o_bad) begin
            errors++; $display("FAIL long_wait: reqc=%0d lat=%0d ades=%b bad=%b want 21 23 0 0",
                               o_reqc, o_lat, o_ades, o_bad);
        end
    endtask
`endif

    task automatic test_reset_mid_bus();
        @(negedge clk);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h20; req_addr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_bus: bus_req=%b busy=%b want 1 1", bus_req, busy);
        end
        reset = 1'b1; req_valid = 1'b0;
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, busy, resp_valid, resp_rdata,
             exc_adel, exc_ades} !== '0) begin
            errors++; $display("FAIL reset_mid_bus: bus_req=%b busy=%b bus_be=%b want all 0",
                               bus_req, busy, bus_be);
        end
        @(negedge clk);
        reset = 1'b0;
        do_access(LW, 32'h0000_0024, 32'h0, 1'b0, 0, 32'h0BAD_F00D);
        checks++;
        if (o_lat !== 3 || o_rdata !== 32'h0BAD_F00D || o_addr !== 32'h24) begin
            errors++; $display("FAIL post_reset_lw: lat=%0d rdata=%h addr=%h want 3 0badf00d 24",
                               o_lat, o_rdata, o_addr);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_loads();
        test_store_wait();
        test_faults();
        test_stray_ack();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m_mem_access_ctrl.md
Name: m_mem_access_ctrl

Overview:
- Memory-stage load/store unit. Consumes the effective address and the address-overflow flags produced by the E-stage ALU.
- Performs the alignment and address-map checks, and drives a req/ack data bus toward DM and the timer/interrupt-generator bridge.
- Returns the extended load data plus AdEL/AdES exception flags to the pipeline.
- Stalls the pipeline while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max BUS-state cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; asynchronous, active-high.
- req_valid  input  1  M-stage load/store present; held stable while busy=1.
- req_op  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- req_addr  input  32  effective address (ALU result).
- req_wdata  input  32  store data (rt).
- req_addr_ovf  input  1  ALU signalled 32-bit signed overflow of base+offset.
- bus_req  output  1  transaction request.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word-aligned address, {req_addr[31:2],2'b00}.
- bus_be  output  4  byte-lane enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_ack  input  1  transaction complete; bus_rdata valid this cycle for reads.
- bus_rdata  input  32  read word.
- busy  output  1  stall request to the pipeline.
- resp_valid  output  1  one-cycle completion strobe.
- resp_rdata  output  32  extended load result; 0 for stores and faults.
- exc_adel  output  1  load address error; valid with resp_valid.
- exc_ades  output  1  store address error; valid with resp_valid.

Behaviour:
- FSM states: IDLE, BUS, RESP. Reset (asynchronous) forces IDLE with every output 0. Reset during BUS drops bus_req immediately and the transaction is abandoned.
- IDLE, req_valid=1:
  - busy=1 combinationally.
  - Fault checks evaluated; request fields registered.
  - Fault present: go to RESP with the matching flag; no bus traffic.
  - No fault: go to BUS.
- Fault conditions, any one true:
  - req_addr_ovf=1.
  - Misaligned: word with addr[1:0]!=0, half with addr[0]!=0.
  - Address outside the legal map: DM 0x0000_0000-0x0000_2FFF, TC0 0x0000_7F00-0x0000_7F0B, TC1 0x0000_7F10-0x0000_7F1B, interrupt generator 0x0000_7F20-0x0000_7F23.
  - Half or byte access to any TC range.
  - Store to a TC count register (0x7F08 or 0x7F18).
  - Loads raise exc_adel; stores raise exc_ades.
- BUS:
  - bus_req=1 with bus_we/addr/be/wdata held constant until the cycle bus_ack=1.
  - In the ack cycle: capture bus_rdata, go to RESP.
  - bus_req drops in the cycle after the ack.
  - busy=1 throughout BUS.
- RESP: resp_valid=1 for exactly one cycle, busy=0, then IDLE. req_valid is ignored in RESP.
- Latency:
  - Zero-wait ack: 3 cycles from req_valid (IDLE, BUS, RESP).
  - Fault: 2 cycles.
  - Each wait cycle adds 1.
- Byte lanes:
  - Word: be=1111.
  - Half: be=0011 for addr[1]=0, 1100 for addr[1]=1; wdata={2{wdata[15:0]}}.
  - Byte: be=0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - Loads drive be identically; bus_we=0.
- Load extension: select the lane by the registered addr[1:0]. lh/lb sign-extend; lhu/lbu zero-extend; lw passes the word through.
- bus_ack outside BUS is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUS.
  - After TIMEOUT_CYCLES cycles without bus_ack: deassert bus_req, go to RESP with exc_adel (load) or exc_ades (store), resp_rdata=0.
  - An ack arriving in the same cycle as expiry wins and the access completes normally.
- Undefined: BUS waits indefinitely; no counter logic is synthesized.

Test Plan:
- lw addr 0x0000_1004, ack on first BUS cycle, rdata 0x1234_5678 -> bus_be=1111, bus_addr=0x1004; resp_valid on cycle 3; resp_rdata=0x1234_5678; no exception.
- lb addr 0x0000_0003, rdata 0x80FF_0000 -> be=1000, resp_rdata=0xFFFF_FF80. Same access as lbu -> 0x0000_0080.
- sh addr 0x0000_0102, wdata 0xAAAA_BEEF, ack after 4 wait cycles -> bus_wdata=0xBEEF_BEEF, be=1100, bus_req held 5 cycles, busy high until RESP.
- lw addr 0x0000_0002 -> exc_adel=1 on cycle 2, bus_req never asserted. sw to 0x0000_7F08 -> exc_ades=1. sb to 0x0000_7F00 -> exc_ades=1. lw with req_addr_ovf=1 -> exc_adel=1.
- lw addr 0x0000_3000 (outside DM) -> exc_adel=1, no bus traffic.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no ack on sw 0x0000_0010 -> bus_req drops after 8 BUS cycles, exc_ades=1 with resp_valid. Second run: assert reset mid-BUS -> all outputs 0 immediately, state IDLE.
